// File: rtl/ex_md_stage_pkg.sv
// Shared types for the EX stage: ALU/MD opcodes, MD FSM states, forwarding selects.
// EX_MADD_EN enables the MADD/MADDU/MSUB/MSUBU encodings; otherwise they act as MD_NONE.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_t;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Ops that launch a multi-cycle operation.
  function automatic logic md_is_start(md_op_t op);
`ifdef EX_MADD_EN
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
                      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`endif
  endfunction

  // Ops that touch HI/LO and therefore must wait while the unit is busy.
  function automatic logic md_is_active(md_op_t op);
    return (op inside {MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO}) || md_is_start(op);
  endfunction

endpackage

// File: rtl/ex_md_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the EX stage, bundled for port hookup.
interface ex_md_stage_if import ex_pkg::*; #(parameter int unsigned W = 32);

  logic         flush;
  logic [W-1:0] pc_in;
  alu_op_t      alu_op;
  md_op_t       md_op;
  logic         imm_sel;
  logic [W-1:0] imm_in;
  logic [W-1:0] rs_in;
  logic [W-1:0] rt_in;
  logic [1:0]   fwd_a_sel;
  logic [1:0]   fwd_b_sel;
  logic [W-1:0] fwd_mem;
  logic [W-1:0] fwd_wb;
  logic [4:0]   wa_in;
  logic         wr_en_in;
  logic [2:0]   tnew_in;
  logic [W-1:0] wd_in;

  logic         md_stall;
  logic [W-1:0] pc_out;
  logic [W-1:0] res_out;
  logic [W-1:0] rt_out;
  logic [4:0]   wa_out;
  logic         wr_en_out;
  logic [2:0]   tnew_out;
  logic [W-1:0] wd_out;

  modport master (
    output flush, pc_in, alu_op, md_op, imm_sel, imm_in, rs_in, rt_in,
           fwd_a_sel, fwd_b_sel, fwd_mem, fwd_wb, wa_in, wr_en_in, tnew_in, wd_in,
    input  md_stall, pc_out, res_out, rt_out, wa_out, wr_en_out, tnew_out, wd_out
  );

  modport slave (
    input  flush, pc_in, alu_op, md_op, imm_sel, imm_in, rs_in, rt_in,
           fwd_a_sel, fwd_b_sel, fwd_mem, fwd_wb, wa_in, wr_en_in, tnew_in, wd_in,
    output md_stall, pc_out, res_out, rt_out, wa_out, wr_en_out, tnew_out, wd_out
  );

endinterface

// File: rtl/ex_md_stage_md_unit.sv
// Multi-cycle multiply/divide unit: HI/LO registers, IDLE/BUSY FSM with latency counter.
// Operands are latched at start; the result is written to HI/LO on the final busy cycle.
module md_unit import ex_pkg::*; #(
  parameter int unsigned W       = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  md_op_t       md_op,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  md_state_t      state;
  logic [CNT_W-1:0] count;
  md_op_t         op_q;
  logic [W-1:0]   a_q, b_q;

  logic           sgn_mul, neg_a, neg_b;
  logic [2*W-1:0] prod, acc;
  logic [W-1:0]   mag_a, mag_b, uq, ur, quot, rem;

  // Result datapath on the latched operands; divide works on magnitudes then fixes signs.
  always_comb begin
    sgn_mul = op_q inside {MD_MULT, MD_MADD, MD_MSUB};
    if (sgn_mul) prod = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};
    else         prod = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    if (op_q inside {MD_MSUB, MD_MSUBU}) acc = {hi, lo} - prod;
    else                                 acc = {hi, lo} + prod;
    neg_a = (op_q == MD_DIV) && a_q[W-1];
    neg_b = (op_q == MD_DIV) && b_q[W-1];
    mag_a = neg_a ? -a_q : a_q;
    mag_b = neg_b ? -b_q : b_q;
    uq    = (mag_b == '0) ? '0 : mag_a / mag_b;
    ur    = (mag_b == '0) ? '0 : mag_a % mag_b;
    quot  = (neg_a ^ neg_b) ? -uq : uq;
    rem   = neg_a ? -ur : ur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      count <= '0;
      op_q  <= MD_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (!flush) begin
            if (md_is_start(md_op)) begin
              state <= MD_BUSY;
              op_q  <= md_op;
              a_q   <= op_a;
              b_q   <= op_b;
              count <= (md_op inside {MD_DIV, MD_DIVU}) ? CNT_W'(DIV_LAT - 1)
                                                      : CNT_W'(MUL_LAT - 1);
            end else if (md_op == MD_MTHI) begin
              hi <= op_a;
            end else if (md_op == MD_MTLO) begin
              lo <= op_a;
            end
          end
        end
        MD_BUSY: begin
          if (count == '0) begin
            state <= MD_IDLE;
            case (op_q)
              MD_MULT, MD_MULTU:                     {hi, lo} <= prod;
              MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: {hi, lo} <= acc;
              MD_DIV, MD_DIVU: begin
                // Divide by zero leaves HI/LO untouched.
                if (b_q != '0) begin
                  lo <= quot;
                  hi <= rem;
                end
              end
              default: ;
            endcase
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/ex_md_stage.sv
// MIPS EX stage: operand forwarding, ALU, mul/div unit and the EX/MEM pipeline register.
// Define EX_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module ex_md_stage import ex_pkg::*; #(
  parameter int unsigned W       = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input logic         clk,
  input logic         reset,
  ex_md_stage_if.slave bus
);

  localparam int unsigned SH_W = $clog2(W);

  logic [W-1:0] op_a, rt_f, op_b, alu_res, result, hi, lo;
  logic         busy;

  // Forwarding muxes; select 3 falls back to the register value.
  always_comb begin
    case (bus.fwd_a_sel)
      FWD_MEM: op_a = bus.fwd_mem;
      FWD_WB:  op_a = bus.fwd_wb;
      default: op_a = bus.rs_in;
    endcase
    case (bus.fwd_b_sel)
      FWD_MEM: rt_f = bus.fwd_mem;
      FWD_WB:  rt_f = bus.fwd_wb;
      default: rt_f = bus.rt_in;
    endcase
    op_b = bus.imm_sel ? bus.imm_in : rt_f;
  end

  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLT:  alu_res = W'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_res = W'(op_a < op_b);
      ALU_SLL:  alu_res = op_b << op_a[SH_W-1:0];
      ALU_SRL:  alu_res = op_b >> op_a[SH_W-1:0];
      ALU_SRA:  alu_res = W'($signed(op_b) >>> op_a[SH_W-1:0]);
      ALU_LUI:  alu_res = {op_b[W/2-1:0], {(W/2){1'b0}}};
      default:  alu_res = '0;
    endcase
    if (bus.md_op == MD_MFHI)      result = hi;
    else if (bus.md_op == MD_MFLO) result = lo;
    else                           result = alu_res;
  end

  // MD operands are the forwarded rs/rt; the immediate never feeds the mul/div unit.
  md_unit #(.W(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_md (
    .clk   (clk),
    .reset (reset),
    .flush (bus.flush),
    .md_op (bus.md_op),
    .op_a  (op_a),
    .op_b  (rt_f),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  assign bus.md_stall = md_is_active(bus.md_op) && busy;

  always_ff @(posedge clk) begin
    if (reset || bus.flush || bus.md_stall) begin
      bus.pc_out    <= '0;
      bus.res_out   <= '0;
      bus.rt_out    <= '0;
      bus.wa_out    <= '0;
      bus.wr_en_out <= 1'b0;
      bus.tnew_out  <= '0;
      bus.wd_out    <= '0;
    end else begin
      bus.pc_out    <= bus.pc_in;
      bus.res_out   <= result;
      bus.rt_out    <= rt_f;
      bus.wa_out    <= bus.wa_in;
      bus.wr_en_out <= bus.wr_en_in;
      bus.tnew_out  <= (bus.tnew_in == 3'd0) ? 3'd0 : bus.tnew_in - 3'd1;
      bus.wd_out    <= (bus.tnew_in == 3'd0) ? bus.wd_in :
                       (bus.tnew_in == 3'd1) ? result : '0;
    end
  end

endmodule

// File: tb/tb_ex_md_stage.sv
// Randomized self-checking bench for ex_md_stage against a behavioural pipeline/HI-LO model.
// Honours EX_MADD_EN the same way the design does.
module tb_ex_md_stage;
  import ex_pkg::*;

  localparam int unsigned W       = 32;
  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ex_md_stage_if #(.W(W)) bus();

  ex_md_stage #(.W(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: architectural HI/LO and the cycle at which the unit becomes free.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          busy_until = 0;

  function automatic bit madd_enabled();
`ifdef EX_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit md_counts(md_op_t op);
    if (op >= MD_MADD) return madd_enabled();
    return op != MD_NONE;
  endfunction

  function automatic logic [31:0] pick(logic [1:0] sel, logic [31:0] r, logic [31:0] m, logic [31:0] w);
    if (sel == 2'd1) return m;
    if (sel == 2'd2) return w;
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(alu_op_t op, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return b << a[4:0];
      ALU_SRL:  return b >> a[4:0];
      ALU_SRA:  return 32'(sb >>> a[4:0]);
      ALU_LUI:  return b * 32'h10000;
      default:  return 32'd0;
    endcase
  endfunction

  // Apply an accepted MD op to the model; results become visible once busy ends.
  task automatic model_md(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up, hl;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sp = sa * sb;
    up = {32'h0, a} * {32'h0, b};
    hl = {m_hi, m_lo};
    case (op)
      MD_MULT:  begin hl = sp; busy_until = cyc + 1 + MUL_LAT; end
      MD_MULTU: begin hl = up; busy_until = cyc + 1 + MUL_LAT; end
      MD_DIV, MD_DIVU: begin
        if (b != 32'd0) begin
          if (op == MD_DIV) begin sq = sa / sb; sr = sa % sb; end
          else begin sq = longint'(a / b); sr = longint'(a % b); end
          hl = {32'(sr), 32'(sq)};
        end
        busy_until = cyc + 1 + DIV_LAT;
      end
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
        if (madd_enabled()) begin
          if (op == MD_MADD)       hl = hl + sp;
          else if (op == MD_MADDU) hl = hl + up;
          else if (op == MD_MSUB)  hl = hl - sp;
          else                     hl = hl - up;
          busy_until = cyc + 1 + MUL_LAT;
        end
      end
      MD_MTHI: hl[63:32] = a;
      MD_MTLO: hl[31:0]  = a;
      default: ;
    endcase
    {m_hi, m_lo} = hl;
  endtask

  task automatic set_nop();
    bus.flush = 1'b0; bus.pc_in = '0; bus.alu_op = ALU_ADD; bus.md_op = MD_NONE;
    bus.imm_sel = 1'b0; bus.imm_in = '0; bus.rs_in = '0; bus.rt_in = '0;
    bus.fwd_a_sel = 2'd0; bus.fwd_b_sel = 2'd0; bus.fwd_mem = '0; bus.fwd_wb = '0;
    bus.wa_in = '0; bus.wr_en_in = 1'b0; bus.tnew_in = '0; bus.wd_in = '0;
  endtask

  task automatic rand_fields();
    bus.pc_in = $urandom; bus.alu_op = alu_op_t'(4'($urandom_range(0, 11)));
    bus.imm_sel = 1'($urandom_range(0, 1)); bus.imm_in = $urandom;
    bus.rs_in = $urandom; bus.rt_in = $urandom; bus.fwd_mem = $urandom; bus.fwd_wb = $urandom;
    bus.fwd_a_sel = 2'($urandom_range(0, 3)); bus.fwd_b_sel = 2'($urandom_range(0, 3));
    bus.wa_in = 5'($urandom); bus.wr_en_in = 1'($urandom); bus.tnew_in = 3'($urandom);
    bus.wd_in = $urandom;
  endtask

  // Present the current inputs as one instruction; hold it through any stall, then check EX/MEM.
  task automatic run_instr(input string name, output int stalls);
    logic [31:0] a, rtf, b, res, e_wd, e_pc, e_rt;
    logic [4:0]  e_wa;
    logic        e_we;
    logic [2:0]  e_tn;
    bit          counts, exp_stall, fl;
    stalls = 0;
    counts = md_counts(bus.md_op);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp_stall = counts && (cyc < busy_until);
      total++;
      if (bus.md_stall !== exp_stall) begin
        bad++;
        $display("FAIL %s md_stall: got %b want %b (cycle %0d)", name, bus.md_stall, exp_stall, cyc);
      end
      if (!exp_stall) break;
      stalls++;
      @(posedge clk); #1;
      total++;
      if ({bus.pc_out, bus.res_out, bus.rt_out, bus.wa_out, bus.wr_en_out, bus.tnew_out, bus.wd_out} !== '0) begin
        bad++;
        $display("FAIL %s stall_bubble: got res=%h pc=%h we=%b want all zero", name, bus.res_out, bus.pc_out, bus.wr_en_out);
      end
    end
    a   = pick(bus.fwd_a_sel, bus.rs_in, bus.fwd_mem, bus.fwd_wb);
    rtf = pick(bus.fwd_b_sel, bus.rt_in, bus.fwd_mem, bus.fwd_wb);
    b   = bus.imm_sel ? bus.imm_in : rtf;
    if (bus.md_op == MD_MFHI)      res = m_hi;
    else if (bus.md_op == MD_MFLO) res = m_lo;
    else                           res = alu_ref(bus.alu_op, a, b);
    fl   = bus.flush;
    e_pc = bus.pc_in; e_rt = rtf; e_wa = bus.wa_in; e_we = bus.wr_en_in;
    e_tn = (bus.tnew_in == 3'd0) ? 3'd0 : 3'(bus.tnew_in - 3'd1);
    e_wd = (bus.tnew_in == 3'd0) ? bus.wd_in : (bus.tnew_in == 3'd1) ? res : 32'd0;
    if (fl) begin
      e_pc = '0; res = '0; e_rt = '0; e_wa = '0; e_we = 1'b0; e_tn = '0; e_wd = '0;
    end else begin
      model_md(bus.md_op, a, rtf);
    end
    @(posedge clk); #1;
    total += 7;
    if (bus.pc_out !== e_pc)       begin bad++; $display("FAIL %s pc_out: got %h want %h", name, bus.pc_out, e_pc); end
    if (bus.res_out !== res)       begin bad++; $display("FAIL %s res_out: got %h want %h", name, bus.res_out, res); end
    if (bus.rt_out !== e_rt)       begin bad++; $display("FAIL %s rt_out: got %h want %h", name, bus.rt_out, e_rt); end
    if (bus.wa_out !== e_wa)       begin bad++; $display("FAIL %s wa_out: got %h want %h", name, bus.wa_out, e_wa); end
    if (bus.wr_en_out !== e_we)    begin bad++; $display("FAIL %s wr_en_out: got %b want %b", name, bus.wr_en_out, e_we); end
    if (bus.tnew_out !== e_tn)     begin bad++; $display("FAIL %s tnew_out: got %0d want %0d", name, bus.tnew_out, e_tn); end
    if (bus.wd_out !== e_wd)       begin bad++; $display("FAIL %s wd_out: got %h want %h", name, bus.wd_out, e_wd); end
  endtask

  task automatic md_instr(input string name, input md_op_t op, input logic [31:0] rs, input logic [31:0] rt, output int stalls);
    set_nop();
    bus.md_op = op; bus.rs_in = rs; bus.rt_in = rt;
    run_instr(name, stalls);
  endtask

  task automatic test_reset();
    set_nop();
    bus.md_op = MD_MFHI;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_hi = '0; m_lo = '0; busy_until = 0;
    total += 2;
    if ({bus.pc_out, bus.res_out, bus.rt_out, bus.wa_out, bus.wr_en_out, bus.tnew_out, bus.wd_out} !== '0) begin
      bad++; $display("FAIL reset_outputs: got res=%h pc=%h want all zero", bus.res_out, bus.pc_out);
    end
    if (bus.md_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.md_stall); end
    reset = 1'b0;
  endtask

  task automatic test_forwarding();
    int s;
    set_nop();
    bus.pc_in = 32'h100; bus.rs_in = 32'd1; bus.fwd_mem = 32'd7; bus.fwd_a_sel = 2'd1;
    bus.rt_in = 32'd3; bus.fwd_b_sel = 2'd0; bus.tnew_in = 3'd1; bus.wr_en_in = 1'b1; bus.wa_in = 5'd8;
    run_instr("fwd_basic", s);
    total += 3;
    if (bus.res_out !== 32'd10) begin bad++; $display("FAIL fwd_res: got %h want 0000000a", bus.res_out); end
    if (bus.wd_out !== 32'd10)  begin bad++; $display("FAIL fwd_wd: got %h want 0000000a", bus.wd_out); end
    if (bus.tnew_out !== 3'd0)  begin bad++; $display("FAIL fwd_tnew: got %0d want 0", bus.tnew_out); end
    for (int i = 0; i < 30; i++) begin
      set_nop(); rand_fields();
      bus.flush = ($urandom_range(0, 7) == 0);
      run_instr("alu_rand", s);
    end
  endtask

  task automatic test_mult();
    int s;
    md_instr("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, s);
    md_instr("mult_mfhi", MD_MFHI, 32'd0, 32'd0, s);
    total += 2;
    if (s != MUL_LAT) begin bad++; $display("FAIL mult_busy_cycles: got %0d want %0d", s, MUL_LAT); end
    if (bus.res_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", bus.res_out); end
    md_instr("mult_mflo", MD_MFLO, 32'd0, 32'd0, s);
    total++;
    if (bus.res_out !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_lo: got %h want fffffffe", bus.res_out); end
    md_instr("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, s);
    md_instr("multu_mfhi", MD_MFHI, 32'd0, 32'd0, s);
    total++;
    if (bus.res_out !== 32'd1) begin bad++; $display("FAIL multu_hi: got %h want 00000001", bus.res_out); end
    md_instr("multu_mflo", MD_MFLO, 32'd0, 32'd0, s);
    for (int i = 0; i < 6; i++) begin
      md_instr("mul_rand", (i % 2) ? MD_MULTU : MD_MULT, $urandom, $urandom, s);
      md_instr("mul_rand_hi", MD_MFHI, 32'd0, 32'd0, s);
      md_instr("mul_rand_lo", MD_MFLO, 32'd0, 32'd0, s);
    end
  endtask

  task automatic test_div();
    int s;
    logic [31:0] d;
    md_instr("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, s);
    md_instr("div_mflo", MD_MFLO, 32'd0, 32'd0, s);
    total += 2;
    if (s != DIV_LAT) begin bad++; $display("FAIL div_stall_cycles: got %0d want %0d", s, DIV_LAT); end
    if (bus.res_out !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", bus.res_out); end
    md_instr("div_mfhi", MD_MFHI, 32'd0, 32'd0, s);
    total++;
    if (bus.res_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", bus.res_out); end
    for (int i = 0; i < 8; i++) begin
      d = ($urandom_range(0, 1) == 0) ? (32'($urandom_range(0, 20)) - 32'd10) : $urandom;
      md_instr("div_rand", (i % 2) ? MD_DIVU : MD_DIV, $urandom, d, s);
      md_instr("div_rand_lo", MD_MFLO, 32'd0, 32'd0, s);
      md_instr("div_rand_hi", MD_MFHI, 32'd0, 32'd0, s);
    end
  endtask

  task automatic test_div_zero();
    int s;
    md_instr("mthi", MD_MTHI, 32'h11, 32'd0, s);
    md_instr("mtlo", MD_MTLO, 32'h22, 32'd0, s);
    md_instr("divu_zero", MD_DIVU, 32'd5, 32'd0, s);
    md_instr("divz_mfhi", MD_MFHI, 32'd0, 32'd0, s);
    total += 2;
    if (s != DIV_LAT) begin bad++; $display("FAIL divz_stall_cycles: got %0d want %0d", s, DIV_LAT); end
    if (bus.res_out !== 32'h11) begin bad++; $display("FAIL divz_hi: got %h want 00000011", bus.res_out); end
    md_instr("divz_mflo", MD_MFLO, 32'd0, 32'd0, s);
    total++;
    if (bus.res_out !== 32'h22) begin bad++; $display("FAIL divz_lo: got %h want 00000022", bus.res_out); end
  endtask

  task automatic test_reset_mid_op();
    int s;
    md_instr("pre_mthi", MD_MTHI, 32'h55, 32'd0, s);
    md_instr("rst_mult", MD_MULT, 32'd3, 32'd5, s);
    md_instr("rst_gap0", MD_NONE, 32'd0, 32'd0, s);
    set_nop(); bus.md_op = MD_MFHI;
    reset = 1'b1;
    @(posedge clk); #1;
    m_hi = '0; m_lo = '0; busy_until = 0;
    total += 2;
    if (bus.md_stall !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", bus.md_stall); end
    if ({bus.pc_out, bus.res_out, bus.rt_out, bus.wa_out, bus.wr_en_out, bus.tnew_out, bus.wd_out} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs: got res=%h pc=%h want all zero", bus.res_out, bus.pc_out);
    end
    reset = 1'b0;
    md_instr("rst_mfhi", MD_MFHI, 32'd0, 32'd0, s);
    md_instr("rst_mflo", MD_MFLO, 32'd0, 32'd0, s);
  endtask

  task automatic test_flush();
    int s;
    md_instr("fl_mtlo5", MD_MTLO, 32'h5, 32'd0, s);
    set_nop(); bus.md_op = MD_MTLO; bus.rs_in = 32'd9; bus.flush = 1'b1; bus.wr_en_in = 1'b1; bus.pc_in = 32'h40;
    run_instr("fl_mtlo9", s);
    md_instr("fl_mflo", MD_MFLO, 32'd0, 32'd0, s);
    total++;
    if (bus.res_out !== 32'h5) begin bad++; $display("FAIL flush_lo: got %h want 00000005", bus.res_out); end
    set_nop(); bus.md_op = MD_MULT; bus.rs_in = 32'd3; bus.rt_in = 32'd4; bus.flush = 1'b1;
    run_instr("fl_mult", s);
    md_instr("fl_mfhi", MD_MFHI, 32'd0, 32'd0, s);
    total++;
    if (s != 0) begin bad++; $display("FAIL flush_start_stall: got %0d want 0", s); end
  endtask

  task automatic test_madd();
    int s;
    md_instr("ma_mthi", MD_MTHI, 32'd0, 32'd0, s);
    md_instr("ma_mtlo", MD_MTLO, 32'hFFFF_FFFF, 32'd0, s);
    md_instr("maddu", MD_MADDU, 32'd1, 32'd1, s);
    md_instr("ma_mfhi", MD_MFHI, 32'd0, 32'd0, s);
    total += 2;
`ifdef EX_MADD_EN
    if (s != MUL_LAT) begin bad++; $display("FAIL madd_stall_cycles: got %0d want %0d", s, MUL_LAT); end
    if (bus.res_out !== 32'd1) begin bad++; $display("FAIL madd_hi: got %h want 00000001", bus.res_out); end
`else
    if (s != 0) begin bad++; $display("FAIL madd_stall_cycles: got %0d want 0", s); end
    if (bus.res_out !== 32'd0) begin bad++; $display("FAIL madd_hi: got %h want 00000000", bus.res_out); end
`endif
    md_instr("ma_mflo", MD_MFLO, 32'd0, 32'd0, s);
    for (int i = 0; i < 4; i++) begin
      md_instr("macc_rand", md_op_t'(4'(9 + i)), $urandom, $urandom, s);
      md_instr("macc_hi", MD_MFHI, 32'd0, 32'd0, s);
      md_instr("macc_lo", MD_MFLO, 32'd0, 32'd0, s);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    for (int i = 0; i < 40; i++) begin
      set_nop(); rand_fields();
      bus.md_op = md_op_t'(4'($urandom_range(0, 12)));
      bus.flush = ($urandom_range(0, 7) == 0);
      run_instr("b2b", s);
    end
  endtask

  initial begin
    set_nop();
    test_reset();
    test_forwarding();
    test_mult();
    test_div();
    test_div_zero();
    test_reset_mid_op();
    test_flush();
    test_madd();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
